// File: rtl/alu_mc_if.sv
// Request/response bundle for the multi-cycle ALU: operands and opcode in,
// busy/done handshake plus registered result and status flags out.
interface alu_mc_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] z;
  logic             zero_flag;
  logic             carry_flag;
  logic             neg_flag;
  logic             ovf_flag;

  modport master (
    output start, op, x, y,
    input  busy, done, z, zero_flag, carry_flag, neg_flag, ovf_flag
  );

  modport slave (
    input  start, op, x, y,
    output busy, done, z, zero_flag, carry_flag, neg_flag, ovf_flag
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: logic/arith ops finish in one cycle, shifts iterate one bit
// per cycle and MUL runs a WIDTH-step unsigned shift-add multiply.
module alu_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic   clk,
  input logic   rst_n,
  alu_mc_if.slave bus
);
  localparam int unsigned CntW = SHW + 1;

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpAdd = 3'b001;
  localparam logic [2:0] OpSub = 3'b010;
  localparam logic [2:0] OpNop = 3'b011;
  localparam logic [2:0] OpOr  = 3'b100;
  localparam logic [2:0] OpSll = 3'b101;
  localparam logic [2:0] OpSrl = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  typedef enum logic [0:0] {StIdle, StExec} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;       // shift operand, or product high half
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d; // becomes product low half
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             zero_q, zero_d, carry_q, carry_d, neg_q, neg_d, ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   add_full, sub_full, mul_sum;
  logic [SHW-1:0]   shamt;
  logic             add_ovf, sub_ovf;
  logic             wr;
  logic [WIDTH-1:0] res;
  logic             res_c, res_v;

  assign add_full = {1'b0, bus.x} + {1'b0, bus.y};
  assign sub_full = {1'b0, bus.x} - {1'b0, bus.y};
  assign add_ovf  = (bus.x[WIDTH-1] == bus.y[WIDTH-1]) && (add_full[WIDTH-1] != bus.x[WIDTH-1]);
  assign sub_ovf  = (bus.x[WIDTH-1] != bus.y[WIDTH-1]) && (sub_full[WIDTH-1] != bus.x[WIDTH-1]);
  assign shamt    = bus.y[SHW-1:0];
  assign mul_sum  = {1'b0, acc_q} + ({1'b0, mcand_q} & {(WIDTH + 1){mplier_q[0]}});

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    z_d      = z_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    wr       = 1'b0;
    res      = '0;
    res_c    = 1'b0;
    res_v    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          unique case (bus.op)
            OpAnd: begin wr = 1'b1; res = bus.x & bus.y; end
            OpOr:  begin wr = 1'b1; res = bus.x | bus.y; end
            OpNop: wr = 1'b1;
            OpAdd: begin
              wr    = 1'b1;
              res   = add_full[WIDTH-1:0];
              res_c = add_full[WIDTH];
              res_v = add_ovf;
            end
            OpSub: begin
              wr    = 1'b1;
              res   = sub_full[WIDTH-1:0];
              res_c = sub_full[WIDTH];
              res_v = sub_ovf;
            end
            OpSll, OpSrl: begin
              if (shamt == '0) begin
                wr  = 1'b1;
                res = bus.x;
              end else begin
                op_d    = bus.op;
                acc_d   = bus.x;
                cnt_d   = {1'b0, shamt};
                state_d = StExec;
              end
            end
            OpMul: begin
              op_d     = bus.op;
              acc_d    = '0;
              mcand_d  = bus.x;
              mplier_d = bus.y;
              cnt_d    = CntW'(WIDTH);
              state_d  = StExec;
            end
          endcase
        end
      end
      StExec: begin
        cnt_d = cnt_q - CntW'(1);
        if (op_q == OpSll) begin
          acc_d = acc_q << 1;
          res_c = acc_q[WIDTH-1];
          res   = acc_d;
        end else if (op_q == OpSrl) begin
          acc_d = acc_q >> 1;
          res_c = acc_q[0];
          res   = acc_d;
        end else begin
          acc_d    = mul_sum[WIDTH:1];
          mplier_d = {mul_sum[0], mplier_q[WIDTH-1:1]};
          res      = mplier_d;
          res_c    = |acc_d;
        end
        if (cnt_q == CntW'(1)) begin
          wr      = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Result and flags only move on completion, so iteration values stay hidden.
    if (wr) begin
      z_d     = res;
      zero_d  = (res == '0);
      neg_d   = res[WIDTH-1];
      carry_d = res_c;
      ovf_d   = res_v;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= OpAnd;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      z_q      <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      z_q      <= z_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy       = (state_q == StExec);
  assign bus.done       = done_q;
  assign bus.z          = z_q;
  assign bus.zero_flag  = zero_q;
  assign bus.carry_flag = carry_q;
  assign bus.neg_flag   = neg_q;
  assign bus.ovf_flag   = ovf_q;
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed vectors push expected results into a queue that a
// negedge monitor pops and compares on every done pulse.
module tb_alu_mc;
  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpAdd = 3'b001;
  localparam logic [2:0] OpSub = 3'b010;
  localparam logic [2:0] OpNop = 3'b011;
  localparam logic [2:0] OpOr  = 3'b100;
  localparam logic [2:0] OpSll = 3'b101;
  localparam logic [2:0] OpSrl = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  typedef struct packed {
    logic [31:0] z;
    logic [3:0]  f; // {zero, carry, neg, ovf}
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t sb[$];

  alu_mc_if #(.WIDTH(32)) bus ();

  alu_mc #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags_now();
    return {bus.zero_flag, bus.carry_flag, bus.neg_flag, bus.ovf_flag};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no done (z=%h)", bus.z);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("z", bus.z, e.z);
        chk("flags", {28'd0, flags_now()}, {28'd0, e.f});
      end
    end
  end

  // Issue one op, scramble the inputs after acceptance, and check latency.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ez, input logic [3:0] ef,
                        input int elat);
    int lat;
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.x     = a;
    bus.y     = b;
    e.z = ez;
    e.f = ef;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = OpAdd;
    bus.x     = ~a;
    bus.y     = ~b;
    lat = 1;
    while (!bus.done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, lat, elat);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.op    = OpAdd;
    bus.x     = 32'h1;
    bus.y     = 32'h1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_z", bus.z, 32'h0);
    chk("reset_busy_done", {30'd0, bus.busy, bus.done}, 32'h0);
    chk("reset_flags", {28'd0, flags_now()}, 32'h0);
    bus.start = 1'b0;
    rst_n     = 1'b1;

    //       name        op     x             y             z             {Z,C,N,V} lat
    run_op("add_ovf",  OpAdd, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0011, 1);
    run_op("sub_eq",   OpSub, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1000, 1);
    run_op("sub_brw",  OpSub, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b0110, 1);
    run_op("mul_hi",   OpMul, 32'h00010000, 32'h00010000, 32'h00000000, 4'b1100, 33);
    run_op("srl4",     OpSrl, 32'h80000001, 32'h00000004, 32'h08000000, 4'b0000, 5);
    run_op("sll0",     OpSll, 32'h12345678, 32'h00000000, 32'h12345678, 4'b0000, 1);
    run_op("sll2",     OpSll, 32'hC0000001, 32'h00000002, 32'h00000004, 4'b0100, 3);
    run_op("srl_wrap", OpSrl, 32'hFFFFFFFF, 32'h00000020, 32'hFFFFFFFF, 4'b0010, 1);
    run_op("mul_small",OpMul, 32'h00000007, 32'h00000006, 32'h0000002A, 4'b0000, 33);
    run_op("and",      OpAnd, 32'h000000F0, 32'h0000003C, 32'h00000030, 4'b0000, 1);
    run_op("or",       OpOr,  32'h000000F0, 32'h8000000F, 32'h800000FF, 4'b0010, 1);
    run_op("nop",      OpNop, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 4'b1000, 1);
    run_op("add_wrap", OpAdd, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1100, 1);
    run_op("sub_ovf",  OpSub, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001, 1);

    // Back-to-back: second start lands in the first op's done cycle.
    run_op("b2b_add",  OpAdd, 32'h00000001, 32'h00000001, 32'h00000002, 4'b0000, 1);
    run_op("b2b_and",  OpAnd, 32'h000000F0, 32'h0000003C, 32'h00000030, 4'b0000, 1);

    // Abort a MUL with reset; the ignored ADD and the MUL must never complete.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OpMul;
    bus.x     = 32'h3;
    bus.y     = 32'h5;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OpAdd;
    bus.x     = 32'h1;
    bus.y     = 32'h1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_mid_mul", {31'd0, bus.busy}, 32'h1);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_z", bus.z, 32'h0);
    chk("abort_busy_done", {30'd0, bus.busy, bus.done}, 32'h0);
    chk("abort_flags", {28'd0, flags_now()}, 32'h0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    run_op("post_reset", OpAdd, 32'h00000002, 32'h00000003, 32'h00000005, 4'b0000, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
